vedic_mul_unit: RTL and testbench

Multi-cycle 32x32 integer multiply unit for the execute stage of the in-order single-issue pipeline. It consumes the combinational Vedic multiplier cells: a 16x16 Vedic core built hierarchically from the 2-bit `vedic2bmul` cells is reused over four cycles, and the partial products are accumulated into a 64-bit result. It implements the RISC-V M-extension MUL/MULH/MULHSU/MULHU operations behind a valid/ready handshake on both sides.

---
 rtl/vedic_mul_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_vedic_mul_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_unit.sv
// Multi-cycle 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU) that reuses one 16x16 Vedic core over four steps.
// Optional macro MUL_EARLY_OUT_EN: a zero operand skips straight to DONE one edge after acceptance.

module vedic2bmul (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic w_cross0;
    logic w_cross1;
    logic w_carry;
    logic w_high;

    assign w_cross0 = a[1] & b[0];
    assign w_cross1 = a[0] & b[1];
    assign w_carry  = w_cross0 & w_cross1;
    assign w_high   = a[1] & b[1];
    assign p = {w_high & w_carry, w_high ^ w_carry, w_cross0 ^ w_cross1, a[0] & b[0]};
endmodule

module vedic_mul4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] w_q0, w_q1, w_q2, w_q3;
    logic [5:0] w_mid;

    vedic2bmul u_q0 (.a(a[1:0]), .b(b[1:0]), .p(w_q0));
    vedic2bmul u_q1 (.a(a[3:2]), .b(b[1:0]), .p(w_q1));
    vedic2bmul u_q2 (.a(a[1:0]), .b(b[3:2]), .p(w_q2));
    vedic2bmul u_q3 (.a(a[3:2]), .b(b[3:2]), .p(w_q3));

    assign w_mid = {2'b00, w_q1} + {2'b00, w_q2};
    assign p = {4'b0000, w_q0} + {w_mid, 2'b00} + {w_q3, 4'b0000};
endmodule

module vedic_mul8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [7:0] w_q0, w_q1, w_q2, w_q3;
    logic [9:0] w_mid;

    vedic_mul4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(w_q0));
    vedic_mul4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(w_q1));
    vedic_mul4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(w_q2));
    vedic_mul4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(w_q3));

    assign w_mid = {2'b00, w_q1} + {2'b00, w_q2};
    assign p = {8'h00, w_q0} + {2'b00, w_mid, 4'h0} + {w_q3, 8'h00};
endmodule

module vedic_mul16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    logic [15:0] w_q0, w_q1, w_q2, w_q3;
    logic [17:0] w_mid;

    vedic_mul8 u_q0 (.a(a[7:0]),  .b(b[7:0]),  .p(w_q0));
    vedic_mul8 u_q1 (.a(a[15:8]), .b(b[7:0]),  .p(w_q1));
    vedic_mul8 u_q2 (.a(a[7:0]),  .b(b[15:8]), .p(w_q2));
    vedic_mul8 u_q3 (.a(a[15:8]), .b(b[15:8]), .p(w_q3));

    assign w_mid = {2'b00, w_q1} + {2'b00, w_q2};
    assign p = {16'h0000, w_q0} + {6'b000000, w_mid, 8'h00} + {w_q3, 16'h0000};
endmodule

module vedic_mul_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int HALF = XLEN / 2;
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGNFIX, S_DONE} state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [1:0]         r_step;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_opA;
    logic [XLEN-1:0]    r_opB;
    logic [1:0]         r_op;
    logic [TAG_W-1:0]   r_tag;
    logic               r_neg;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_outTag;
    logic               r_outValid;

    logic               w_signA;
    logic               w_signB;
    logic [XLEN-1:0]    w_magA;
    logic [XLEN-1:0]    w_magB;
    logic [HALF-1:0]    w_coreA;
    logic [HALF-1:0]    w_coreB;
    logic [XLEN-1:0]    w_partial;
    logic [1:0]         w_shift;
    logic [2*XLEN-1:0]  w_shifted;
    logic [2*XLEN-1:0]  w_accFixed;
`ifdef MUL_EARLY_OUT_EN
    logic               w_opZero;
    assign w_opZero = (rs1 == '0) || (rs2 == '0);
`endif

    // Operands are stored as magnitudes so the Vedic core only ever sees unsigned halves.
    assign w_signA = rs1[XLEN-1] && ((op == OP_MULH) || (op == OP_MULHSU));
    assign w_signB = rs2[XLEN-1] && (op == OP_MULH);
    assign w_magA  = w_signA ? -rs1 : rs1;
    assign w_magB  = w_signB ? -rs2 : rs2;

    assign w_coreA   = r_step[0] ? r_opA[XLEN-1:HALF] : r_opA[HALF-1:0];
    assign w_coreB   = r_step[1] ? r_opB[XLEN-1:HALF] : r_opB[HALF-1:0];
    assign w_shift   = {1'b0, r_step[0]} + {1'b0, r_step[1]};
    assign w_shifted = {{XLEN{1'b0}}, w_partial} << {w_shift, 4'b0000};
    assign w_accFixed = r_neg ? -r_acc : r_acc;

    vedic_mul16 u_core (.a(w_coreA), .b(w_coreB), .p(w_partial));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        in_ready    = (r_state == S_IDLE) && !rst;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef MUL_EARLY_OUT_EN
                    w_stateNext = w_opZero ? S_DONE : S_CALC;
`else
                    w_stateNext = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (r_step == 2'd3) begin
                    w_stateNext = S_SIGNFIX;
                end
            end
            S_SIGNFIX: w_stateNext = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Step k picks halves i=k[0], j=k[1]; the 2-bit step counter wraps back to 0 after the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step     <= 2'd0;
            r_acc      <= '0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_op       <= 2'b00;
            r_tag      <= '0;
            r_neg      <= 1'b0;
            r_result   <= '0;
            r_outTag   <= '0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op   <= op;
                        r_tag  <= in_tag;
                        r_opA  <= w_magA;
                        r_opB  <= w_magB;
                        r_neg  <= w_signA ^ w_signB;
                        r_acc  <= '0;
                        r_step <= 2'd0;
`ifdef MUL_EARLY_OUT_EN
                        if (w_opZero) begin
                            r_result   <= '0;
                            r_outTag   <= in_tag;
                            r_outValid <= 1'b1;
                        end
`endif
                    end
                end
                S_CALC: begin
                    r_acc  <= r_acc + w_shifted;
                    r_step <= r_step + 2'd1;
                end
                S_SIGNFIX: begin
                    r_acc      <= w_accFixed;
                    r_result   <= (r_op == OP_MUL) ? w_accFixed[XLEN-1:0] : w_accFixed[2*XLEN-1:XLEN];
                    r_outTag   <= r_tag;
                    r_outValid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                    end
                end
                default: r_outValid <= 1'b0;
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign result    = r_result;
    assign out_tag   = r_outTag;
endmodule

// File: tb/tb_vedic_mul_unit.sv
// Directed bench for vedic_mul_unit: hand-computed RV32M products, latency, backpressure and reset-abort.
// Honours MUL_EARLY_OUT_EN when choosing the expected latency of zero-operand ops.

module tb_vedic_mul_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    vedic_mul_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, observed, expected);
        end
    endtask

    // Reference product built from sign-extended 64-bit operands.
    function automatic logic [31:0] modelMul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] prod;
        ea = ((o == 2'b01) || (o == 2'b10)) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        prod = ea * eb;
        return (o == 2'b00) ? prod[31:0] : prod[63:32];
    endfunction

    // Issues one op, waits for the result, optionally stalls the consumer, then completes the handshake.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag, input int holdCycles,
                                 output logic [31:0] res, output logic [4:0] resTag,
                                 output int lat, output int violations);
        int guard;
        guard = 0;
        violations = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("inReadyBeforeAccept", 64'(in_ready), 64'd1);
        op = opIn; rs1 = a; rs2 = b; in_tag = tag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1 = ~a; rs2 = ~b; in_tag = ~tag;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready || !busy) violations++;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        resTag = out_tag;
        for (int c = 0; c < holdCycles; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== res || out_tag !== resTag || in_ready !== 1'b0) violations++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) violations++;
    endtask

    task automatic runVector(input string name, input logic [1:0] opIn, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] tag, input logic [31:0] expected,
                             input int holdCycles);
        logic [31:0] res;
        logic [4:0]  resTag;
        int lat;
        int violations;
        int expLat;
        expLat = 5;
`ifdef MUL_EARLY_OUT_EN
        if (a == 32'h0 || b == 32'h0) expLat = 0;
`endif
        applyStimulus(opIn, a, b, tag, holdCycles, res, resTag, lat, violations);
        checkOutput({name, ".result"}, 64'(res), 64'(expected));
        checkOutput({name, ".tag"}, 64'(resTag), 64'(tag));
        checkOutput({name, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, ".protocol"}, 64'(violations), 64'd0);
    endtask

    initial begin
        int quietErr;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;

        @(posedge clk); @(posedge clk); #1;
        checkOutput("rstInReady", 64'(in_ready), 64'd0);
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstResult", 64'(result), 64'd0);
        checkOutput("rstOutTag", 64'(out_tag), 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("inReadyAfterRst", 64'(in_ready), 64'd1);

        runVector("mul7x6",        2'b00, 32'd7,        32'd6,        5'd3,  32'd42,        0);
        runVector("mulhMinSq",     2'b01, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000,  0);
        runVector("mulAllOnes",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000001,  0);
        runVector("mulhAllOnes",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000,  0);
        runVector("mulhsuAllOnes", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF,  0);
        runVector("mulhuAllOnes",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE,  0);
        runVector("mulhNeg2x3",    2'b01, 32'hFFFFFFFE, 32'd3,        5'd9,  32'hFFFFFFFF,  0);
        runVector("mulCross",      2'b00, 32'h00010003, 32'h00020005, 5'd10, 32'h000B000F,  0);
        runVector("mulhuCross",    2'b11, 32'h00010000, 32'h00010000, 5'd11, 32'h00000001,  0);
        runVector("mulZero",       2'b00, 32'h0,        32'h1234,     5'd12, 32'h0,         0);
        runVector("backpressure",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE,  10);

        // Abort an op so that reset lands on the edge that would run step 2.
        op = 2'b00; rs1 = 32'd9; rs2 = 32'd9; in_tag = 5'd21; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        checkOutput("inReadyDuringRst", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("abortInReady", 64'(in_ready), 64'd1);
        checkOutput("abortOutValid", 64'(out_valid), 64'd0);
        checkOutput("abortResult", 64'(result), 64'd0);
        checkOutput("abortOutTag", 64'(out_tag), 64'd0);
        checkOutput("abortBusy", 64'(busy), 64'd0);
        quietErr = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) quietErr++;
        end
        checkOutput("abortNoOutput", 64'(quietErr), 64'd0);
        runVector("afterAbort", 2'b00, 32'd3, 32'd5, 5'd22, 32'd15, 0);

        for (int n = 0; n < 40; n++) begin
            ro = 2'(n % 4);
            ra = $urandom();
            rb = $urandom();
            if (n % 5 == 0) ra[31] = 1'b1;
            runVector($sformatf("rand%0d", n), ro, ra, rb, 5'(n), modelMul(ro, ra, rb), n % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
